// File: rtl/peripheral_bb_pkg.sv
// Shared Wishbone encodings, FSM state type and the burst address generator
// for the peripheral slave memory.
package peripheral_bb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic WB_READ  = 1'b0;
    localparam logic WB_WRITE = 1'b1;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        ERR
    } state_e;

    // Linear results are reduced modulo DEPTH by the caller truncating to its index width.
    function automatic logic [31:0] next_index(input logic [31:0] idx,
                                               input logic [2:0]  cti,
                                               input bte_e        bte);
        logic [31:0] nxt;
        nxt = idx;
        if (cti == CTI_INCR) begin
            unique case (bte)
                BTE_LINEAR: nxt = idx + 32'd1;
                BTE_WRAP4:  nxt = {idx[31:2], idx[1:0] + 2'd1};
                BTE_WRAP8:  nxt = {idx[31:3], idx[2:0] + 3'd1};
                BTE_WRAP16: nxt = {idx[31:4], idx[3:0] + 4'd1};
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/peripheral_slave_mem_bb_if.sv
// Wishbone B4 bus bundle between a master and the slave memory.
interface peripheral_slave_mem_bb_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   wb_adr_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic [2:0]      wb_cti_i;
    logic [1:0]      wb_bte_i;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic            wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/peripheral_slave_mem_ram_bb.sv
// Single-port DEPTH x DW RAM with byte enables and synchronous, write-first read.
module peripheral_slave_mem_ram_bb #(
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic                     wb_clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [DW/8-1:0]          sel,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);
    localparam int SEL_W = DW / 8;

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; contents survive reset and map onto block RAM.
    always_ff @(posedge wb_clk) begin
        for (int b = 0; b < SEL_W; b++) begin
            if (we && sel[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                rdata[b*8 +: 8]     <= wdata[b*8 +: 8];
            end else begin
                rdata[b*8 +: 8]     <= mem[addr][b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/peripheral_slave_mem_bb.sv
// Wishbone slave memory: classic and burst cycles, programmable wait states,
// out-of-range and burst-address checking with error termination.
module peripheral_slave_mem_bb
    import peripheral_bb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                        wb_clk,
    input  logic                        wb_rst,
    peripheral_slave_mem_bb_if.slave    wb
);
    localparam int SEL_W  = DW / 8;
    localparam int LSB    = $clog2(SEL_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WORD_W = AW - LSB;

    state_e            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [IDX_W-1:0]  cur_idx, nxt_idx, adr_idx, ram_addr;
    logic [WORD_W-1:0] adr_word;
    logic [31:0]       pred_full;
    logic              we_q;
    logic [2:0]        cti_q;
    bte_e              bte_q;
    logic              in_range, match, burst, load, advance, ack, err, ram_we;
    logic [DW-1:0]     ram_q;
    logic              unused_bits;

    assign adr_word  = wb.wb_adr_i[AW-1:LSB];
    assign adr_idx   = adr_word[IDX_W-1:0];
    assign in_range  = (adr_word >> IDX_W) == '0;
    assign match     = adr_word == WORD_W'(cur_idx);
    assign burst     = (cti_q == CTI_CONST) || (cti_q == CTI_INCR);
    assign pred_full = next_index(32'(cur_idx), cti_q, bte_q);
    assign nxt_idx   = pred_full[IDX_W-1:0];
    assign unused_bits = ^{wb.wb_adr_i, pred_full};

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_idx <= '0;
            we_q    <= WB_READ;
            cti_q   <= CTI_CLASSIC;
            bte_q   <= BTE_LINEAR;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                cur_idx <= adr_idx;
                we_q    <= wb.wb_we_i;
                cti_q   <= wb.wb_cti_i;
                bte_q   <= bte_e'(wb.wb_bte_i);
            end else if (advance) begin
                cur_idx <= nxt_idx;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_n  = state;
        cnt_n    = cnt;
        load     = 1'b0;
        advance  = 1'b0;
        ack      = 1'b0;
        err      = 1'b0;
        ram_addr = cur_idx;
        unique case (state)
            IDLE: begin
                // Read is issued from the live address so data is ready in the first ack cycle.
                ram_addr = adr_idx;
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    load = 1'b1;
                    if (!in_range)             state_n = ERR;
                    else if (WAIT_STATES == 0) state_n = ACK;
                    else begin
                        state_n = WAIT;
                        cnt_n   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt_n == '0) state_n = ACK;
            end
            ACK: begin
                if (wb.wb_stb_i) begin
                    if (!match) begin
                        state_n = ERR;
                    end else begin
                        ack = 1'b1;
                        if (!burst || wb.wb_cti_i == CTI_END) begin
                            state_n = IDLE;
                        end else begin
                            // Prefetch the predicted beat so bursts sustain one ack per cycle.
                            advance = 1'b1;
                            if (we_q == WB_READ) ram_addr = nxt_idx;
                        end
                    end
                end
            end
            ERR: begin
                err     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (!wb.wb_cyc_i) begin
            state_n = IDLE;
            cnt_n   = '0;
            load    = 1'b0;
            advance = 1'b0;
            ack     = 1'b0;
            err     = 1'b0;
        end
    end

    assign ram_we = ack && (we_q == WB_WRITE);

    peripheral_slave_mem_ram_bb #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .wb_clk (wb_clk),
        .addr   (ram_addr),
        .we     (ram_we),
        .sel    (wb.wb_sel_i),
        .wdata  (wb.wb_dat_i),
        .rdata  (ram_q)
    );

    assign wb.wb_ack_o = ack;
    assign wb.wb_err_o = err;
    assign wb.wb_rty_o = 1'b0;
    assign wb.wb_dat_o = ack ? ram_q : '0;
endmodule

// File: tb/tb_peripheral_slave_mem_bb.sv
// Directed bench for the Wishbone slave memory: zero- and three-wait-state instances.
module tb_peripheral_slave_mem_bb;
    import peripheral_bb_pkg::*;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b0;
    always #5 wb_clk = ~wb_clk;

    logic        dut_sel = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic [3:0]  sel = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;

    peripheral_slave_mem_bb_if #(.DW(32), .AW(32)) bus0 ();
    peripheral_slave_mem_bb_if #(.DW(32), .AW(32)) bus3 ();

    assign bus0.wb_cyc_i = cyc & ~dut_sel;
    assign bus3.wb_cyc_i = cyc & dut_sel;
    assign bus0.wb_stb_i = stb;  assign bus3.wb_stb_i = stb;
    assign bus0.wb_we_i  = we;   assign bus3.wb_we_i  = we;
    assign bus0.wb_adr_i = adr;  assign bus3.wb_adr_i = adr;
    assign bus0.wb_dat_i = wdat; assign bus3.wb_dat_i = wdat;
    assign bus0.wb_sel_i = sel;  assign bus3.wb_sel_i = sel;
    assign bus0.wb_cti_i = cti;  assign bus3.wb_cti_i = cti;
    assign bus0.wb_bte_i = bte;  assign bus3.wb_bte_i = bte;

    peripheral_slave_mem_bb #(.DW(32), .AW(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .wb_clk (wb_clk), .wb_rst (wb_rst), .wb (bus0));
    peripheral_slave_mem_bb #(.DW(32), .AW(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
        .wb_clk (wb_clk), .wb_rst (wb_rst), .wb (bus3));

    logic        ack_m, err_m;
    logic [31:0] dat_m;
    assign ack_m = dut_sel ? bus3.wb_ack_o : bus0.wb_ack_o;
    assign err_m = dut_sel ? bus3.wb_err_o : bus0.wb_err_o;
    assign dat_m = dut_sel ? bus3.wb_dat_o : bus0.wb_dat_o;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        bit          d;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        bit          exp_err;
        int          exp_lat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input bit d, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s, input bit e,
                       input int lat, input logic [31:0] ed);
        vec_t v;
        v.name = n; v.d = d; v.we = w; v.adr = a; v.wdat = wd; v.sel = s;
        v.exp_err = e; v.exp_lat = lat; v.exp_dat = ed;
        vq.push_back(v);
    endtask

    // Called just after a rising edge; returns there after one idle cycle.
    task automatic classic(input bit d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, output logic got_ack, output logic got_err,
                           output int lat, output logic [31:0] rd);
        dut_sel = d; we = w; adr = a; wdat = wd; sel = s; cti = CTI_CLASSIC; bte = 2'b00;
        cyc = 1'b1; stb = 1'b1;
        got_ack = 1'b0; got_err = 1'b0; lat = -1; rd = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge wb_clk);
            if (ack_m || err_m) begin
                got_ack = ack_m; got_err = err_m; rd = dat_m; lat = n - 1;
                break;
            end
        end
        @(posedge wb_clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge wb_clk); #1;
    endtask

    initial begin
        logic        ga, ge;
        int          gl;
        logic [31:0] rd;
        logic [4:0]  pat;

        #3;
        check("rst_dut0", {bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_rty_o, bus0.wb_dat_o}, '0);
        check("rst_dut3", {bus3.wb_ack_o, bus3.wb_err_o, bus3.wb_rty_o, bus3.wb_dat_o}, '0);
        repeat (2) @(posedge wb_clk);
        #1 wb_rst = 1'b1;

        add("wr_deadbeef", 0, 1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 1, '0);
        add("rd_deadbeef", 0, 0, 32'h10,  '0,           4'hF, 0, 1, 32'hDEADBEEF);
        add("wr_11223344", 0, 1, 32'h20,  32'h11223344, 4'hF, 0, 1, '0);
        add("wr_sel0010",  0, 1, 32'h20,  32'hAABBCCDD, 4'h2, 0, 1, '0);
        add("rd_merge",    0, 0, 32'h20,  '0,           4'hF, 0, 1, 32'h1122CC44);
        add("wr_sel0000",  0, 1, 32'h20,  32'hFFFFFFFF, 4'h0, 0, 1, '0);
        add("rd_sel0000",  0, 0, 32'h20,  '0,           4'hF, 0, 1, 32'h1122CC44);
        add("wr_sel1100",  0, 1, 32'h20,  32'hA5A5A5A5, 4'hC, 0, 1, '0);
        add("rd_sel1100",  0, 0, 32'h20,  '0,           4'hF, 0, 1, 32'hA5A5CC44);
        add("wr_last",     0, 1, 32'h3FC, 32'h0BADF00D, 4'hF, 0, 1, '0);
        add("rd_oor",      0, 0, 32'h400, '0,           4'hF, 1, 1, '0);
        add("wr_oor",      0, 1, 32'hFFFC, 32'hFFFFFFFF, 4'hF, 1, 1, '0);
        add("rd_last",     0, 0, 32'h3FC, '0,           4'hF, 0, 1, 32'h0BADF00D);
        add("ws3_wr",      1, 1, 32'h0,   32'h12345678, 4'hF, 0, 4, '0);
        add("ws3_rd",      1, 0, 32'h0,   '0,           4'hF, 0, 4, 32'h12345678);
        for (int i = 0; i < 4; i++)
            add($sformatf("wr_init%0d", i), 0, 1, 32'(i * 4), 32'hA0000000 + 32'(i), 4'hF, 0, 1, '0);
        add("wr_init5",    0, 1, 32'h14,  32'h55555555, 4'hF, 0, 1, '0);
        add("wr_init6",    0, 1, 32'h18,  32'h66666666, 4'hF, 0, 1, '0);

        foreach (vq[i]) begin
            classic(vq[i].d, vq[i].we, vq[i].adr, vq[i].wdat, vq[i].sel, ga, ge, gl, rd);
            check({vq[i].name, "_term"}, {ga, ge, 8'(gl)}, {~vq[i].exp_err, vq[i].exp_err, 8'(vq[i].exp_lat)});
            if (!vq[i].we || vq[i].exp_err)
                check({vq[i].name, "_dat"}, rd, vq[i].exp_dat);
        end

        // Back-to-back classic reads with strobe held: acks must be separated by an idle cycle.
        dut_sel = 1'b0; we = 1'b0; adr = 32'h10; cti = CTI_CLASSIC; cyc = 1'b1; stb = 1'b1;
        pat = '0;
        for (int i = 4; i >= 0; i--) begin
            @(negedge wb_clk);
            pat[i] = ack_m;
            if (i == 3) check("b2b_dat", dat_m, 32'hDEADBEEF);
            @(posedge wb_clk);
            if (i == 0) #1 cyc = 1'b0;
        end
        check("b2b_pattern", pat, 5'b01010);
        @(negedge wb_clk);
        check("b2b_cyc_drop", {ack_m, err_m}, 2'b00);
        stb = 1'b0;
        @(posedge wb_clk); #1;

        // Wrap4 read burst from index 2 with one stall cycle.
        dut_sel = 1'b0; we = 1'b0; adr = 32'h08; cti = CTI_INCR; bte = BTE_WRAP4;
        cyc = 1'b1; stb = 1'b1;
        @(posedge wb_clk);
        @(negedge wb_clk); check("wrap_b0", {ack_m, dat_m}, {1'b1, 32'hA0000002});
        @(posedge wb_clk); #1 adr = 32'h0C;
        @(negedge wb_clk); check("wrap_b1", {ack_m, dat_m}, {1'b1, 32'hA0000003});
        @(posedge wb_clk); #1 adr = 32'h00; stb = 1'b0;
        @(negedge wb_clk); check("wrap_stall", {ack_m, err_m, dat_m}, '0);
        @(posedge wb_clk); #1 stb = 1'b1;
        @(negedge wb_clk); check("wrap_b2", {ack_m, dat_m}, {1'b1, 32'hA0000000});
        @(posedge wb_clk); #1 adr = 32'h04; cti = CTI_END;
        @(negedge wb_clk); check("wrap_b3", {ack_m, dat_m}, {1'b1, 32'hA0000001});
        @(posedge wb_clk); #1 cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        @(negedge wb_clk); check("wrap_done", {ack_m, err_m}, 2'b00);
        @(posedge wb_clk); #1;

        // Linear burst whose second beat presents the wrong address.
        adr = 32'h00; cti = CTI_INCR; bte = BTE_LINEAR; cyc = 1'b1; stb = 1'b1;
        @(posedge wb_clk);
        @(negedge wb_clk); check("mm_b1", {ack_m, err_m, dat_m}, {2'b10, 32'hA0000000});
        @(posedge wb_clk); #1 adr = 32'h08;
        @(negedge wb_clk); check("mm_b2", {ack_m, err_m}, 2'b00);
        @(posedge wb_clk);
        @(negedge wb_clk); check("mm_err", {ack_m, err_m, dat_m}, {2'b01, 32'h0});
        @(posedge wb_clk); #1 cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
        @(negedge wb_clk); check("mm_done", {ack_m, err_m}, 2'b00);
        @(posedge wb_clk); #1;

        // Reset asserted during beat 2 of an incrementing write burst.
        we = 1'b1; adr = 32'h14; wdat = 32'h01010101; sel = 4'hF; cti = CTI_INCR;
        cyc = 1'b1; stb = 1'b1;
        @(posedge wb_clk);
        @(negedge wb_clk); check("rb_b1", {ack_m, err_m}, 2'b10);
        @(posedge wb_clk);
        #1 adr = 32'h18; wdat = 32'h02020202;
        #1 check("rb_b2_pre", {ack_m, err_m}, 2'b10);
        wb_rst = 1'b0;
        #1 check("rb_async", {bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_rty_o, bus0.wb_dat_o}, '0);
        #1 cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        @(posedge wb_clk); #1 wb_rst = 1'b1;
        @(posedge wb_clk); #1;
        classic(0, 0, 32'h14, '0, 4'hF, ga, ge, gl, rd);
        check("rb_beat1_kept", {ga, rd}, {1'b1, 32'h01010101});
        classic(0, 0, 32'h18, '0, 4'hF, ga, ge, gl, rd);
        check("rb_beat2_unwritten", {ga, rd}, {1'b1, 32'h66666666});
        check("rty_low", {bus0.wb_rty_o, bus3.wb_rty_o}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/peripheral_slave_mem_bb.md
PERIPHERAL_SLAVE_MEM_BB -- requirements
Module: peripheral_slave_mem_bb

Interface
REQ-001 Parameter DW, default 32: Wishbone data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 32: Wishbone byte-address width.
REQ-003 Parameter DEPTH, default 256: memory depth in DW-bit words; power of two.
REQ-004 Parameter WAIT_STATES, default 0: idle cycles between request sampled and first ack of a cycle (0..15).
REQ-005 wb_clk  input  1  sole clock; all state changes on rising edge.
REQ-006 wb_rst  input  1  asynchronous, active-low reset.
REQ-007 wb_adr_i  input  AW  byte address; word index = wb_adr_i[AW-1:log2(DW/8)].
REQ-008 wb_dat_i  input  DW  write data.
REQ-009 wb_sel_i  input  DW/8  byte-lane enables.
REQ-010 wb_we_i  input  1  1 = write, 0 = read.
REQ-011 wb_cyc_i, wb_stb_i  input  1 each  cycle valid and strobe.
REQ-012 wb_cti_i  input  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst.
REQ-013 wb_bte_i  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
REQ-014 wb_dat_o  output  DW  read data; all zero when wb_ack_o low.
REQ-015 wb_ack_o, wb_err_o, wb_rty_o  output  1 each  termination; wb_rty_o SHALL be constant 0.

Function
REQ-016 FSM states IDLE, WAIT, ACK, ERR; at most one of wb_ack_o/wb_err_o high per cycle.
REQ-017 IDLE: on wb_cyc_i&wb_stb_i, latch we/adr/cti/bte; word index >= DEPTH -> ERR; else WAIT_STATES=0 -> ACK; else WAIT.
REQ-018 WAIT: down-counter loaded with WAIT_STATES; reaching 0 -> ACK; first ack appears WAIT_STATES+1 cycles after request sampled.
REQ-019 ACK with classic (000) or end (111) beat: wb_ack_o high exactly one cycle, then IDLE; back-to-back classic transfers SHALL have at least one cycle with wb_ack_o low between acks.
REQ-020 ACK with incrementing (010) or constant (001) beat: ack every cycle wb_stb_i is high; wb_stb_i low holds state without ack; beat flagged 111 is the final ack, then IDLE.
REQ-021 Burst next address: constant -> unchanged; linear -> index+1 modulo DEPTH; wrap4/8/16 -> low 2/3/4 index bits increment modulo 4/8/16, upper bits held.
REQ-022 Each burst beat SHALL compare wb_adr_i to the predicted address; mismatch -> ERR instead of ack.
REQ-023 ERR: wb_err_o high one cycle, no memory write, then IDLE.
REQ-024 Read: wb_dat_o = mem[index] in the ack cycle (synchronous read issued one cycle earlier; zero-wait bursts SHALL sustain one beat per cycle).
REQ-025 Write: on ack cycle, bytes with wb_sel_i=1 written; others preserved; wb_sel_i=0 acks without change.
REQ-026 wb_cyc_i low in any state -> IDLE next cycle, no ack/err, no write in that cycle.
REQ-027 Simultaneous read of a word written in the previous cycle SHALL return the new data.

Reset
REQ-028 wb_rst low: wb_ack_o, wb_err_o, wb_rty_o = 0, wb_dat_o = 0, FSM = IDLE, counter = 0, immediately and asynchronously.
REQ-029 Memory contents SHALL NOT be cleared by reset; reset mid-burst aborts without further writes.

Structure
REQ-030 peripheral_bb_pkg SHALL hold CTI/BTE encodings, READ/WRITE constants, FSM state enum.
REQ-031 Sub-module peripheral_slave_mem_ram_bb: single-port byte-enable RAM, DEPTH x DW, synchronous read.
REQ-032 Burst address generator SHALL be a package function (index, cti, bte) -> next index.

Verification
REQ-033 Classic write 0xDEADBEEF @0x10, sel 1111, WAIT_STATES=0; read @0x10 -> ack one cycle after stb, data 0xDEADBEEF.
REQ-034 WAIT_STATES=3, classic read @0x0 -> ack exactly 4 cycles after stb sampled.
REQ-035 Wrap4 read burst from 0x08 (index 2) -> indices 2,3,0,1 acked on consecutive cycles, last with cti 111.
REQ-036 Write 0x11223344 @0x20, then sel 0010 write 0xAABBCCDD -> read returns 0x1122CC44.
REQ-037 Read @ byte 0x400 with DEPTH=256 -> wb_err_o one cycle, no ack; burst address mismatch on beat 2 -> wb_err_o.
REQ-038 wb_rst low mid-incrementing write burst after beat 1 -> outputs 0 same cycle, beat 2 address unchanged in memory.
